// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: two-stage post-add normaliser for the FP datapath.
//
// Stage 1 registers the raw adder result and its leading-zero count. Stage 2
// turns it into the final significand, exponent and flags, held in the
// output registers. Both sides use valid/ready. A full pipe can accept and
// drain in the same cycle without inserting a bubble.
//
// Optional feature (macro FP_NORM_ROUND_EN):
//   defined   - the carry-out path rounds to nearest, ties to even. The
//               guard bit is the bit shifted out of the significand.
//   undefined - the carry-out path truncates. No guard register or rounding
//               logic is built.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_sig, in_exp        raw significand and pre-normalisation exponent
//   in_cout               adder carry-out
//   out_valid / out_ready output handshake
//   out_sig, out_exp      normalised significand and adjusted exponent
//   out_zero              result is zero (true zero or flushed)
//   out_ovf               exponent overflow, result is infinity
//   out_unf               exponent underflow, flushed to zero (sets out_zero too)
module fp_norm_pipe #(
  parameter int unsigned SIG_W = 24,
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_sig,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_sig,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam int unsigned LzW  = $clog2(SIG_W + 1);
  localparam int unsigned CmpW = (EXP_W > LzW) ? EXP_W : LzW;
  localparam logic [EXP_W-1:0] ExpMax = '1;
  // A carry-out at this exponent or above makes exp+1 reach all-ones.
  localparam logic [EXP_W-1:0] ExpOvf = ExpMax - EXP_W'(1);

  // Handshake.
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Leading-zero count of the incoming significand. Later iterations
  // override earlier ones, so the highest set bit decides the count.
  logic [LzW-1:0] in_lz;

  always_comb begin
    in_lz = LzW'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (in_sig[i]) in_lz = LzW'(SIG_W - 1 - i);
    end
  end

  // Stage 1 registers.
  logic [SIG_W-1:0] s1_sig;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_cout;
  logic [LzW-1:0]   s1_lz;
`ifdef FP_NORM_ROUND_EN
  logic             s1_guard;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sig   <= '0;
      s1_exp   <= '0;
      s1_cout  <= 1'b0;
      s1_lz    <= '0;
`ifdef FP_NORM_ROUND_EN
      s1_guard <= 1'b0;
`endif
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sig   <= in_sig;
        s1_exp   <= in_exp;
        s1_cout  <= in_cout;
        s1_lz    <= in_lz;
`ifdef FP_NORM_ROUND_EN
        s1_guard <= in_sig[0];
`endif
      end
    end
  end

  // Stage 2 result. The rules are checked in priority order.
  logic [SIG_W-1:0] n_sig;
  logic [EXP_W-1:0] n_exp;
  logic             n_zero;
  logic             n_ovf;
  logic             n_unf;
  logic [SIG_W-1:0] cout_sig;
  logic [CmpW-1:0]  exp_cmp;
  logic [CmpW-1:0]  lz_cmp;
`ifdef FP_NORM_ROUND_EN
  logic [SIG_W:0]   rnd_sum;
  logic [EXP_W-1:0] rnd_exp;
`endif

  assign cout_sig = {1'b1, s1_sig[SIG_W-1:1]};
  assign exp_cmp  = CmpW'(s1_exp);
  assign lz_cmp   = CmpW'(s1_lz);

  always_comb begin
    n_sig  = '0;
    n_exp  = '0;
    n_zero = 1'b0;
    n_ovf  = 1'b0;
    n_unf  = 1'b0;
`ifdef FP_NORM_ROUND_EN
    rnd_sum = '0;
    rnd_exp = '0;
`endif
    if (s1_cout) begin
      if (s1_exp >= ExpOvf) begin
        n_exp = ExpMax;
        n_ovf = 1'b1;
      end else begin
        n_sig = cout_sig;
        n_exp = s1_exp + EXP_W'(1);
`ifdef FP_NORM_ROUND_EN
        // Ties go to even: increment only when the kept LSB is odd.
        if (s1_guard && cout_sig[0]) begin
          rnd_sum = {1'b0, cout_sig} + (SIG_W + 1)'(1);
          if (rnd_sum[SIG_W]) begin
            rnd_exp = s1_exp + EXP_W'(2);
            if (rnd_exp == ExpMax) begin
              n_sig = '0;
              n_exp = ExpMax;
              n_ovf = 1'b1;
            end else begin
              n_sig = {1'b1, {(SIG_W - 1){1'b0}}};
              n_exp = rnd_exp;
            end
          end else begin
            n_sig = rnd_sum[SIG_W-1:0];
          end
        end
`endif
      end
    end else if (s1_sig == '0) begin
      n_zero = 1'b1;
    end else if (exp_cmp <= lz_cmp) begin
      n_zero = 1'b1;
      n_unf  = 1'b1;
    end else begin
      n_sig = s1_sig << s1_lz;
      n_exp = s1_exp - EXP_W'(s1_lz);
    end
  end

  // Output registers. They hold while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sig   <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sig  <= n_sig;
        out_exp  <= n_exp;
        out_zero <= n_zero;
        out_ovf  <= n_ovf;
        out_unf  <= n_unf;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe (SIG_W=24, EXP_W=8). Expected results
// are queued when a beat is accepted and compared when the result drains.
module tb_fp_norm_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_sig;
  logic [7:0]  in_exp;
  logic        in_cout;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sig;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  fp_norm_pipe #(.SIG_W(24), .EXP_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sig   (in_sig),
    .in_exp   (in_exp),
    .in_cout  (in_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sig  (out_sig),
    .out_exp  (out_exp),
    .out_zero (out_zero),
    .out_ovf  (out_ovf),
    .out_unf  (out_unf)
  );

  typedef struct packed {
    logic [23:0] sig;
    logic [7:0]  exp;
    logic        zero;
    logic        ovf;
    logic        unf;
  } res_t;

  typedef struct packed {
    logic [23:0] sig;
    logic [7:0]  exp;
    logic        cout;
  } stim_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference model, written from the normalisation rules.
  function automatic res_t model(input logic [23:0] s, input logic [7:0] e, input logic c);
    res_t        r;
    int          lz;
    logic [24:0] t;
    logic [23:0] m;
    logic [8:0]  ne;
    r  = '0;
    lz = 24;
    for (int i = 23; i >= 0; i--) begin
      if (s[i]) begin
        lz = 23 - i;
        break;
      end
    end
    if (c) begin
      if (e >= 8'hFE) begin
        r.exp = 8'hFF;
        r.ovf = 1'b1;
      end else begin
        t  = {1'b1, s};
        m  = t[24:1];
        ne = {1'b0, e} + 9'd1;
`ifdef FP_NORM_ROUND_EN
        if (s[0] && m[0]) begin
          t = {1'b0, m} + 25'd1;
          if (t[24]) begin
            m  = 24'h800000;
            ne = ne + 9'd1;
          end else begin
            m = t[23:0];
          end
        end
`endif
        if (ne >= 9'h0FF) begin
          r.exp = 8'hFF;
          r.ovf = 1'b1;
        end else begin
          r.sig = m;
          r.exp = ne[7:0];
        end
      end
    end else if (s == 24'd0) begin
      r.zero = 1'b1;
    end else if (int'(e) <= lz) begin
      r.zero = 1'b1;
      r.unf  = 1'b1;
    end else begin
      r.sig = s << lz;
      r.exp = e - 8'(lz);
    end
    return r;
  endfunction

  // Samples the handshakes 1 time unit after inputs are driven (well before
  // the rising edge), then advances to the next falling edge.
  task automatic tick(output bit acc, output bit fire, output res_t got);
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    got  = {out_sig, out_exp, out_zero, out_ovf, out_unf};
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sig    = '0;
    in_exp    = '0;
    in_cout   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_sig, out_exp, out_zero, out_ovf, out_unf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b sig=%h exp=%h z=%b o=%b u=%b, want all 0",
               out_valid, out_sig, out_exp, out_zero, out_ovf, out_unf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed;
    stim_t st[$];
    res_t  ex[$];
    res_t  g;
    res_t  w;
    bit    acc;
    bit    fire;
    int    sent;
    int    got_n;
    int    budget;
    st.push_back({24'h800003, 8'h80, 1'b1});
`ifdef FP_NORM_ROUND_EN
    ex.push_back({24'hC00002, 8'h81, 3'b000});
`else
    ex.push_back({24'hC00001, 8'h81, 3'b000});
`endif
    st.push_back({24'h000100, 8'h20, 1'b0}); ex.push_back({24'h800000, 8'h11, 3'b000});
    st.push_back({24'h000000, 8'h55, 1'b0}); ex.push_back({24'h000000, 8'h00, 3'b100});
    st.push_back({24'h000001, 8'h10, 1'b0}); ex.push_back({24'h000000, 8'h00, 3'b101});
    st.push_back({24'hFFFFFF, 8'hFE, 1'b1}); ex.push_back({24'h000000, 8'hFF, 3'b010});
    // exp == lz flushes, exp == lz+1 does not.
    st.push_back({24'h000100, 8'h0F, 1'b0}); ex.push_back({24'h000000, 8'h00, 3'b101});
    st.push_back({24'h000100, 8'h10, 1'b0}); ex.push_back({24'h800000, 8'h01, 3'b000});
    // Largest exponent that still takes the carry-out without overflow.
    st.push_back({24'h000000, 8'hFD, 1'b1}); ex.push_back({24'h800000, 8'hFE, 3'b000});
    // All-ones exponent without carry is shifted like any other value.
    st.push_back({24'h400000, 8'hFF, 1'b0}); ex.push_back({24'h800000, 8'hFE, 3'b000});
`ifdef FP_NORM_ROUND_EN
    st.push_back({24'hFFFFFF, 8'h80, 1'b1}); ex.push_back({24'h800000, 8'h82, 3'b000});
    st.push_back({24'hFFFFFF, 8'hFD, 1'b1}); ex.push_back({24'h000000, 8'hFF, 3'b010});
`else
    st.push_back({24'hFFFFFF, 8'h80, 1'b1}); ex.push_back({24'hFFFFFF, 8'h81, 3'b000});
    st.push_back({24'hFFFFFF, 8'hFD, 1'b1}); ex.push_back({24'hFFFFFF, 8'hFE, 3'b000});
`endif
    sent      = 0;
    got_n     = 0;
    budget    = 0;
    out_ready = 1'b1;
    while (got_n < st.size() && budget < 100) begin
      in_valid = (sent < st.size());
      if (sent < st.size()) {in_sig, in_exp, in_cout} = st[sent];
      tick(acc, fire, g);
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL directed_extra: got %h with nothing expected", g);
        end else begin
          w = exp_q.pop_front();
          if (g !== w) begin
            errors++;
            $display("FAIL directed_%0d: got %h want %h", got_n, g, w);
          end
        end
        got_n++;
      end
      if (acc) begin
        exp_q.push_back(ex[sent]);
        sent++;
      end
      budget++;
    end
    in_valid = 1'b0;
    checks++;
    if (got_n != st.size()) begin
      errors++;
      $display("FAIL directed_count: got %0d results want %0d", got_n, st.size());
    end
  endtask

  task automatic test_backpressure;
    stim_t st[3];
    res_t  g;
    res_t  w;
    bit    acc;
    bit    fire;
    int    sent;
    int    got_n;
    int    budget;
    st[0] = {24'h000100, 8'h20, 1'b0};
    st[1] = {24'h800003, 8'h40, 1'b1};
    st[2] = {24'h00F000, 8'h30, 1'b0};
    sent      = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = (sent < 3);
      if (sent < 3) {in_sig, in_exp, in_cout} = st[sent];
      tick(acc, fire, g);
      if (acc) begin
        exp_q.push_back(model(st[sent].sig, st[sent].exp, st[sent].cout));
        sent++;
      end
      if (cyc >= 2) begin
        checks++;
        if (acc || !out_valid || g !== exp_q[0]) begin
          errors++;
          $display("FAIL stall_cyc%0d: got acc=%b valid=%b data=%h want acc=0 valid=1 data=%h",
                   cyc, acc, out_valid, g, exp_q[0]);
        end
      end
    end
    checks++;
    if (sent != 2) begin
      errors++;
      $display("FAIL stall_accepted: got %0d beats want 2", sent);
    end
    out_ready = 1'b1;
    got_n     = 0;
    budget    = 0;
    while (got_n < 3 && budget < 50) begin
      in_valid = (sent < 3);
      if (sent < 3) {in_sig, in_exp, in_cout} = st[sent];
      tick(acc, fire, g);
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL release_extra: got %h with nothing expected", g);
        end else begin
          w = exp_q.pop_front();
          if (g !== w) begin
            errors++;
            $display("FAIL release_%0d: got %h want %h", got_n, g, w);
          end
        end
        got_n++;
      end
      if (acc) begin
        exp_q.push_back(model(st[sent].sig, st[sent].exp, st[sent].cout));
        sent++;
      end
      budget++;
    end
    in_valid = 1'b0;
    repeat (3) tick(acc, fire, g);
    checks++;
    if (got_n != 3 || exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL release_count: got %0d results, %0d left, valid=%b want 3, 0, 0",
               got_n, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_random;
    res_t        g;
    res_t        w;
    bit          acc;
    bit          fire;
    int          sent;
    int          got_n;
    int          budget;
    logic [23:0] s;
    logic [7:0]  e;
    sent   = 0;
    got_n  = 0;
    budget = 0;
    in_valid = 1'b0;
    while (got_n < 60 && budget < 2000) begin
      if (!in_valid && sent < 60) begin
        s = $urandom();
        s = s >> $urandom_range(0, 24);
        case ($urandom_range(0, 5))
          0: e = 8'hFD;
          1: e = 8'hFE;
          2: e = 8'hFF;
          3: e = 8'($urandom_range(0, 24));
          default: e = $urandom();
        endcase
        in_sig   = s;
        in_exp   = e;
        in_cout  = $urandom_range(0, 1);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick(acc, fire, g);
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_extra: got %h with nothing expected", g);
        end else begin
          w = exp_q.pop_front();
          if (g !== w) begin
            errors++;
            $display("FAIL random_%0d: got %h want %h", got_n, g, w);
          end
        end
        got_n++;
      end
      if (acc) begin
        exp_q.push_back(model(in_sig, in_exp, in_cout));
        sent++;
        in_valid = 1'b0;
      end
      budget++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got_n != 60) begin
      errors++;
      $display("FAIL random_count: got %0d results want 60", got_n);
    end
  endtask

  task automatic test_mid_reset;
    res_t g;
    res_t w;
    bit   acc;
    bit   fire;
    int   n;
    bit   seen;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    {in_sig, in_exp, in_cout} = {24'h000100, 8'h20, 1'b0};
    tick(acc, fire, g);
    {in_sig, in_exp, in_cout} = {24'h800003, 8'h80, 1'b1};
    tick(acc, fire, g);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sig, out_exp, out_zero, out_ovf, out_unf} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%b sig=%h exp=%h z=%b o=%b u=%b, want all 0",
               out_valid, out_sig, out_exp, out_zero, out_ovf, out_unf);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    {in_sig, in_exp, in_cout} = {24'h000001, 8'h30, 1'b0};
    tick(acc, fire, g);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL midreset_accept: got acc=%b want 1", acc);
    end
    exp_q.push_back(model(24'h000001, 8'h30, 1'b0));
    in_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      tick(acc, fire, g);
      n++;
      if (fire) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 2) begin
      errors++;
      $display("FAIL midreset_latency: got seen=%b after %0d cycles want seen=1 after 2",
               seen, n);
    end
    if (seen) begin
      w = exp_q.pop_front();
      checks++;
      if (g !== w) begin
        errors++;
        $display("FAIL midreset_data: got %h want %h", g, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Parametrised, pipelined post-add normaliser for the Vector ALU FP datapath. It sits between the significand adder and result writeback.
- Handles carry-out (right shift by 1, exp+1) and cancellation (leading-zero count, left shift, exp-lz).
- Detects zero, exponent overflow and underflow.
- Uses a valid/ready handshake on both sides so it can stall under writeback backpressure.

Parameters:
- SIG_W, 24, significand width including hidden bit.
- EXP_W, 8, biased exponent width (unsigned).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_sig  in  SIG_W  raw adder significand.
- in_exp  in  EXP_W  pre-normalisation exponent.
- in_cout  in  1  adder carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sig  out  SIG_W  normalised significand (MSB=1 unless zero/inf).
- out_exp  out  EXP_W  adjusted exponent.
- out_zero  out  1  result is zero (true zero or flushed).
- out_ovf  out  1  exponent overflow, result is inf.
- out_unf  out  1  exponent underflow, flushed to zero.

Behaviour:
- Reset (async, rst_n=0): both stage valids, out_valid, out_sig, out_exp and all flags go to 0. A beat in flight is discarded. in_ready=1 one cycle after rst_n deasserts.
- Pipeline: 2 register stages, latency 2 cycles from in_valid&in_ready to out_valid when out_ready=1. Throughput 1 beat/cycle.
- S1 captures sig, exp, cout, guard=in_sig[0], lz = leading-zero count of in_sig (0..SIG_W, width clog2(SIG_W+1)).
- S2 computes the result into the output registers.
- Handshake: S2 advances when !out_valid || out_ready. S1 advances when !s1_valid || S2 advances. in_ready = !s1_valid || S2 advances.
- Output data and flags hold stable while out_valid&!out_ready. No beat is dropped or duplicated; order is preserved.
- S2 rules (first match wins):
  - cout=1 and exp >= 2^EXP_W-2: out_exp=all-ones, out_sig=0, out_ovf=1.
  - cout=1: out_sig={cout,sig}>>1 (low SIG_W bits), out_exp=exp+1.
  - sig=0: out_sig=0, out_exp=0, out_zero=1.
  - exp <= lz: out_sig=0, out_exp=0, out_zero=1, out_unf=1.
  - otherwise: out_sig=sig<<lz, out_exp=exp-lz.
- Flags are mutually exclusive except unf, which implies zero. Flags are cleared on every non-flag result.
- in_exp=all-ones with cout=0 passes through the shift rules unchanged; inf/NaN screening is upstream's job.
- Simultaneous in accept and out drain in a full pipe: both stages shift, no bubble.

Optional Feature:
- Macro: FP_NORM_ROUND_EN.
- Defined: on the cout path, round-to-nearest-even using guard (the shifted-out bit).
  - Increment when guard=1 and the shifted LSB=1 (tie to even; there is no sticky input).
  - If the increment carries out of SIG_W: out_sig=1<<(SIG_W-1) and exp is incremented again, then re-check overflow.
  - Rounding adds no latency.
- Undefined: truncation; guard is ignored, and no guard register or round logic is synthesised.

Test Plan:
- cout=1, sig=24'h800003, exp=8'h80 -> 2 cycles later sig=24'hC00001, exp=8'h81, flags 0. With FP_NORM_ROUND_EN: sig=24'hC00002.
- cout=0, sig=24'h000100, exp=8'h20 -> sig=24'h800000, exp=8'h11 (lz=15).
- cout=0, sig=24'h000000, exp=8'h55 -> sig=0, exp=0, out_zero=1. Then cout=0, sig=24'h000001, exp=8'h10 -> sig=0, exp=0, out_zero=1, out_unf=1.
- cout=1, sig=24'hFFFFFF, exp=8'hFE -> exp=8'hFF, sig=0, out_ovf=1.
- Backpressure: 3 back-to-back beats, out_ready=0 for 4 cycles -> in_ready falls after 2 accepted beats. out_valid held with first result stable. On release, results emerge in order with no loss or duplication.
- Assert rst_n=0 mid-stream with 2 beats in flight -> out_valid=0 immediately and all outputs 0. After release, the first new beat appears 2 cycles after acceptance.
